// File: rtl/md_sequencer.sv
// HI/LO multiply/divide scheduler for the E stage: accepts one op, counts out its
// latency, then commits to HI/LO. Define MD_MADD_EN to enable madd/maddu (codes 7/8).
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op_E,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        exc_int,
  input  logic        md_use_D,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        is_multi, is_div, done, sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] abs_a, abs_b, divisor, uq, ur, quo, rem;

  always_comb begin
    is_multi = 1'b0;
    case (op_E)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_multi = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU:                  is_multi = 1'b1;
`endif
      default:                            is_multi = 1'b0;
    endcase
  end

  assign is_div   = (op_E == OP_DIV) || (op_E == OP_DIVU);
  assign start    = is_multi & ~busy & ~exc_int;
  assign stall_md = md_use_D & (start | busy);
  assign done     = (state == RUN) && (cnt == 4'd1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One multiplier serves mult/multu/madd/maddu: sign- or zero-extend to 64 bits,
  // then the low 64 bits of the product are exact for either signedness.
  assign sgn   = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD);
  assign ext_a = sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b = sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = ext_a * ext_b;

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
  assign abs_a   = (sgn && a_q[31]) ? -a_q : a_q;
  assign abs_b   = (sgn && b_q[31]) ? -b_q : b_q;
  assign divisor = (b_q == 32'd0) ? 32'd1 : abs_b;
  assign uq      = abs_a / divisor;
  assign ur      = abs_a % divisor;
  assign quo     = (sgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
  assign rem     = (sgn && a_q[31]) ? -ur : ur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      if (start) begin
        op_q <= op_E;
        a_q  <= D1;
        b_q  <= D2;
        cnt  <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (done) begin
      case (op_q)
        OP_MULT, OP_MULTU: {HI, LO} <= prod;
        OP_DIV, OP_DIVU:   if (b_q != 32'd0) {HI, LO} <= {rem, quo};
`ifdef MD_MADD_EN
        OP_MADD, OP_MADDU: {HI, LO} <= {HI, LO} + prod;
`endif
        default: ;
      endcase
    end else if (~busy & ~exc_int) begin
      if (op_E == OP_MTHI) HI <= D1;
      if (op_E == OP_MTLO) LO <= D1;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized bench for md_sequencer against a timestamp-based behavioural model of
// HI/LO; honours MD_MADD_EN the same way the design does.
module tb_md_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  op_E = 4'd0;
  logic [31:0] D1 = 32'd0, D2 = 32'd0;
  logic        exc_int = 1'b0, md_use_D = 1'b0;
  logic        start, busy, stall_md;
  logic [31:0] HI, LO;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .op_E(op_E), .D1(D1), .D2(D2),
    .exc_int(exc_int), .md_use_D(md_use_D), .start(start), .busy(busy),
    .stall_md(stall_md), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;

  // model: pending op remembered with the cycle it was accepted in
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  bit          pend = 1'b0;
  int          cyc = 0, acc_cyc = 0, n_cyc = 0;
  logic [3:0]  p_op = 4'd0;
  logic [31:0] p_a = 32'd0, p_b = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit multi_op(input logic [3:0] op);
`ifdef MD_MADD_EN
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
`else
    return op inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
  endfunction

  task automatic commit();
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = $signed(p_a);
    sb = $signed(p_b);
    ua = longint'({32'd0, p_a});
    ub = longint'({32'd0, p_b});
    case (p_op)
      4'd1: begin p = sa * sb; {m_hi, m_lo} = p; end
      4'd2: begin p = ua * ub; {m_hi, m_lo} = p; end
      4'd3: if (p_b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (p_b != 0) begin q = ua / ub; r = ua % ub; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd7: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; end
      4'd8: begin p = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} + p; end
      default: ;
    endcase
  endtask

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit exc, input bit use_d, input bit rst);
    bit e_busy, e_start, e_stall;
    op_E = op; D1 = a; D2 = b; exc_int = exc; md_use_D = use_d; reset = rst;
    #1;
    e_busy  = pend;
    e_start = multi_op(op) && !e_busy && !exc;
    e_stall = use_d && (e_start || e_busy);
    if (chk_en) begin
      check("start", 32'(start), 32'(e_start));
      check("busy", 32'(busy), 32'(e_busy));
      check("stall_md", 32'(stall_md), 32'(e_stall));
      check("HI", HI, m_hi);
      check("LO", LO, m_lo);
    end
    @(posedge clk);
    if (rst) begin
      m_hi = 0; m_lo = 0; pend = 0;
    end else begin
      if (pend && cyc == acc_cyc + n_cyc) begin
        commit();
        pend = 0;
      end
      if (e_start) begin
        pend = 1; acc_cyc = cyc; p_op = op; p_a = a; p_b = b;
        n_cyc = (op == 4'd3 || op == 4'd4) ? DC : MC;
      end else if (!exc && !e_busy) begin
        if (op == 4'd5) m_hi = a;
        if (op == 4'd6) m_lo = a;
      end
    end
    cyc++;
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit use_d);
    for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, 1'b0, use_d, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(4'd0, 0, 0, 0, 0, 1);
    step(4'd0, 0, 0, 0, 0, 1);

    // signed mult
    step(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
    idle(MC, 0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // divu then div accepted in the first idle cycle
    step(4'd4, 32'd100, 32'd7, 0, 0, 0);
    idle(DC, 0);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    idle(DC, 0);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // divide by zero keeps HI/LO
    step(4'd5, 32'h11, 0, 0, 0, 0);
    step(4'd6, 32'h22, 0, 0, 0, 0);
    step(4'd3, 32'd9, 32'd0, 0, 0, 0);
    idle(DC, 0);
    check("div0_hi", HI, 32'h11);
    check("div0_lo", LO, 32'h22);

    // flush in the accept cycle, then flush mid-run
    step(4'd1, 32'd5, 32'd6, 1, 0, 0);
    check("exc_busy", 32'(busy), 32'd0);
    step(4'd1, 32'd5, 32'd6, 0, 0, 0);
    step(4'd0, 0, 0, 0, 0, 0);
    step(4'd0, 0, 0, 1, 0, 0);
    idle(MC - 2, 0);
    check("exc_run_lo", LO, 32'd30);

    // stall window and a stall-free mtlo
    step(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0);
    idle(MC, 1);
    step(4'd6, 32'h1234, 0, 0, 0, 0);
    check("mtlo", LO, 32'h1234);
    check("mtlo_stall", 32'(stall_md), 32'd0);

    // maddu wrap of the accumulator
    step(4'd5, 32'd0, 0, 0, 0, 0);
    step(4'd6, 32'hFFFF_FFFF, 0, 0, 0, 0);
    step(4'd8, 32'd1, 32'd1, 0, 0, 0);
    idle(MC, 0);
`ifdef MD_MADD_EN
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
`else
    check("maddu_hi", HI, 32'd0);
    check("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

    // reset in the middle of a divide
    step(4'd3, 32'd50, 32'd3, 0, 0, 0);
    idle(2, 0);
    step(4'd0, 0, 0, 0, 0, 1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lo", LO, 32'd0);
    idle(DC + 2, 0);
    check("rst_nowrite", LO, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      step(op, pick(), pick(), ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide scheduler for the E stage of the five-stage MIPS pipeline. It accepts one decoded HI/LO operation per cycle from E, captures the forwarded operands, and counts out the fixed multiply or divide latency. It commits results to HI/LO on completion and raises the stall request that freezes F/D while a HI/LO-dependent instruction waits in D. It also honours the pipeline's interrupt/exception flush so a cancelled instruction never touches HI/LO.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu (legal range 1–15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1–15)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- op_E  in  4  decoded E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, others none
- D1  in  32  forwarded rs value (E stage)
- D2  in  32  forwarded rt value (E stage)
- exc_int  in  1  exception/interrupt flush this cycle; the E-stage instruction is cancelled
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo/madd class
- start  out  1  combinational; multi-cycle op accepted this cycle
- busy  out  1  registered; computation in progress
- stall_md  out  1  combinational; md_use_D & (start | busy)
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, RUN. Reset puts the block in IDLE with cnt=0, HI=0, LO=0, busy=0.
- Accept condition: op_E in {1,2,3,4,7,8} & ~busy & ~exc_int. This condition drives `start`.
- On accept:
  - latch the op, D1 and D2.
  - load cnt with MULT_CYCLES or DIV_CYCLES.
  - go to RUN.
- RUN:
  - cnt decrements each cycle.
  - When cnt==1, at that edge: write the result, go to IDLE, clear busy.
- mult: {HI,LO} = signed 64-bit D1*D2. multu: unsigned.
- div: LO = signed D1/D2, HI = signed D1%D2. Quotient truncates toward zero; remainder takes the sign of D1. divu: unsigned.
- Divide by zero (D2==0): full DIV_CYCLES busy period; HI/LO unchanged at completion.
- madd/maddu: {HI,LO} += 64-bit signed/unsigned product, modulo 2^64. The accumulator base is the HI/LO value at completion time.
- mthi/mtlo:
  - Single-cycle. HI or LO := D1 at the end of the cycle, when ~exc_int & ~busy.
  - Never asserts start or busy.
- Interaction rules:
  - Any op_E while busy is ignored. The hazard unit guarantees this does not occur; the bench checks HI/LO are unaffected if it does.
  - exc_int during RUN does not cancel. The instruction already left E and completes normally.
  - exc_int with op_E present: no start, no latch, no HI/LO write.

## Timing
- Cycle T: op accepted, start=1. At the T edge, operands are latched and busy goes to 1.
- busy=1 in cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO are written at the edge ending T+N and are readable (mfhi/mflo via forwarding) from T+N+1.
- busy is 0 in T+N+1. A new multi-cycle op may be accepted in T+N+1, giving back-to-back throughput of one op per N+1 cycles.
- stall_md is high in T through T+N whenever md_use_D=1, and low in T+N+1.
- mthi/mtlo in cycle T is visible on HI/LO from T+1.
- Reset asserted mid-RUN: the next edge forces IDLE, busy=0, HI=LO=0, and no result write.

## Configuration
- MD_MADD_EN defined: op codes 7 (madd) and 8 (maddu) are accepted as described.
- MD_MADD_EN undefined: codes 7 and 8 decode as none. No start, busy, or HI/LO effect, and the accumulate adder is not synthesised.

## Test plan
- Reset, then mult D1=0xFFFFFFFE, D2=3 in cycle T:
  - start=1 at T; busy high T+1..T+5.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6.
- divu D1=100, D2=7:
  - busy for 10 cycles.
  - LO=14, HI=2.
  - Then div D1=-7, D2=2 accepted in the first idle cycle gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- HI=0x11, LO=0x22, then div with D2=0:
  - busy 10 cycles.
  - HI=0x11, LO=0x22 unchanged.
- mult with exc_int=1 in the same cycle:
  - start=0, busy stays 0, HI/LO unchanged.
  - mult accepted, then exc_int=1 at T+2: busy continues, result written at T+5 edge.
- md_use_D=1 throughout a mult:
  - stall_md=1 for T..T+5, 0 at T+6.
  - mtlo D1=0x1234 while idle gives LO=0x1234 next cycle with no stall.
- With MD_MADD_EN:
  - HI=0, LO=0xFFFFFFFF, then maddu D1=1, D2=1 gives HI=1, LO=0.
  - Without the macro, the same stimulus leaves HI/LO unchanged and busy=0.
- Reset asserted at T+3 of a divide: busy=0, HI=LO=0 at T+4, and no later write occurs.
